shift_mult_ctrl: RTL and testbench
==================================

# shift_mult_ctrl

Sequencing controller for the shift-add unsigned multiplier built around the N-to-M bit shift register. It accepts a start request and drives the register's Ld/Sh/Di controls and the adder's accumulate enable, one multiplier bit at a time. It signals completion with a one-cycle Done pulse. The controller holds no operand data; it only reads the multiplier LSB (Q0) back from the shift register.

## Interface
- NSIZE, 8, operand width in bits; also the number of shifts per multiply (≥2).
- CNTW, $clog2(NSIZE+1), width of the shift counter.
- Clk  in  1  rising-edge clock.
- Clr  in  1  asynchronous, active-high reset. Forces IDLE and clears all outputs.
- Start  in  1  request a multiply. Sampled only in IDLE.
- Q0  in  1  LSB of the shift register's Q (current multiplier bit).
- Ld  out  1  load pulse to the shift register.
- Sh  out  1  shift enable to the shift register.
- Di  out  1  shift direction to the shift register. Held 0 (right shift) at all times.
- Add  out  1  accumulate enable: partial product += multiplicand.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Cnt  out  CNTW  number of shifts completed in the current operation.

## Operation
- States, one-hot encoded: IDLE, LOAD, TEST, ADD, SHIFT, DONE.
- IDLE:
  - Start=1 → LOAD.
  - Otherwise stay in IDLE.
  - Cnt holds its last value.
- LOAD:
  - Ld=1; Cnt←0.
  - → TEST.
- TEST:
  - Sample Q0.
  - Q0=1 → ADD; Q0=0 → SHIFT.
  - No outputs other than Busy.
- ADD:
  - Add=1.
  - → SHIFT.
- SHIFT:
  - Sh=1, Di=0; Cnt←Cnt+1.
  - If Cnt==NSIZE-1 (i.e. this is the last shift) → DONE; else → TEST.
- DONE:
  - Done=1.
  - → IDLE unconditionally.
- Start in any state other than IDLE is ignored; requests are not queued.
- Start held high continuously: a new operation begins one cycle after DONE, from IDLE.
- Q0 is X or Z in TEST: treat as 0 (no ADD) and take the SHIFT path.
- Ld, Sh and Add are mutually exclusive by construction; at most one is high in any cycle.
- Cnt never exceeds NSIZE and does not wrap within an operation.

## Timing
- Reset:
  - Clr asynchronous. Ld=Sh=Di=Add=Busy=Done=0, Cnt=0, state=IDLE, all immediately on assertion.
  - Clr deasserted → IDLE from the next rising edge.
  - Clr mid-operation aborts with no Done pulse. The shift register contents are then undefined for the system; the requester must restart.
- All outputs are registered (state flops or flops fed from the next-state logic). No combinational path exists from Start or Q0 to any output.
- Latency: let edge 0 be the edge that samples Start=1 in IDLE and P = popcount(multiplier).
  - Cycle 1: LOAD.
  - Cycles 2 … 2N+P+1: TEST/ADD/SHIFT.
  - Cycle 2N+P+2: DONE.
- Q0 is valid in TEST because TEST always follows the LOAD or SHIFT edge that updated the register.
- Back-to-back throughput: one operation per 2N+P+3 cycles.

## Structure
- Package shift_mult_pkg:
  - One-hot state encodings (S_IDLE … S_DONE).
  - Default NSIZE.
  - The DI_RIGHT=1'b0 constant.
  - Shared with the datapath top and the testbench.
- One natural sub-module: shift_mult_cnt, a CNTW-bit counter with sync clear (from LOAD), increment enable (from SHIFT), async Clr and a terminal flag (Cnt==NSIZE-1).
- The FSM and output registers stay in shift_mult_ctrl.

## Test plan
All scenarios use NSIZE=8 with the controller connected to the real shift register and a reference multiplier model.
- Multiplier 0x00, Start pulsed once → zero Add pulses, 8 Sh pulses, Done in cycle 18, Cnt=8, product 0.
- Multiplier 0xFF, multiplicand 0xFF → 8 Add pulses, Done in cycle 26, product 0xFE01.
- Multiplier 0x81 → Add pulses only in the first and last bit slots, Done in cycle 20.
- Start re-pulsed in cycles 5 and 12 of an operation → ignored: no extra Ld, timing unchanged. Start held high continuously → second LOAD exactly one cycle after Done.
- Clr asserted asynchronously mid-SHIFT (between edges) → all outputs 0 immediately, no Done, IDLE after release; next Start runs normally from cycle 1.
- Random multipliers (≥1000) → Ld/Sh/Add never overlap, Di always 0, Busy matches state, latency = 2N+P+2 every time.

Source files
------------

// File: rtl/shift_mult_pkg.sv
// ============================================================================
// Module  : shift_mult_pkg
// Brief   : State encodings and constants shared by the shift-add multiplier
//           controller, its counter, the datapath top and the testbench.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_mult_pkg;

    localparam int NSIZE_DEF = 8;

    // The multiplier only ever shifts toward the LSB.
    localparam logic DI_RIGHT = 1'b0;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_LOAD  = 6'b000010,
        S_TEST  = 6'b000100,
        S_ADD   = 6'b001000,
        S_SHIFT = 6'b010000,
        S_DONE  = 6'b100000
    } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_mult_cnt.sv
// ============================================================================
// Module  : shift_mult_cnt
// Brief   : Shift counter with synchronous clear, increment enable and a
//           terminal flag raised on the count of the final shift.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_mult_cnt #(
    parameter int NSIZE = 8,
    parameter int CNTW  = $clog2(NSIZE + 1)
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            sclr_i,
    input  logic            inc_i,
    output logic [CNTW-1:0] cnt_o,
    output logic            term_o
);

    logic [CNTW-1:0] cnt_q;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            cnt_q <= '0;
        end else if (sclr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == CNTW'(NSIZE - 1));

endmodule

`default_nettype wire

// File: rtl/shift_mult_ctrl.sv
// ============================================================================
// Module  : shift_mult_ctrl
// Brief   : Sequencer for a shift-add unsigned multiplier; drives Ld/Sh/Add
//           one multiplier bit at a time and pulses Done on completion.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_mult_ctrl
    import shift_mult_pkg::*;
#(
    parameter int NSIZE = NSIZE_DEF,
    parameter int CNTW  = $clog2(NSIZE + 1)
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            Start,
    input  logic            Q0,
    output logic            Ld,
    output logic            Sh,
    output logic            Di,
    output logic            Add,
    output logic            Busy,
    output logic            Done,
    output logic [CNTW-1:0] Cnt
);

    state_e state_q;
    state_e state_d;
    logic   ld_q, sh_q, add_q, busy_q, done_q;
    logic   last_shift;

    shift_mult_cnt #(
        .NSIZE (NSIZE),
        .CNTW  (CNTW)
    ) u_cnt (
        .Clk    (Clk),
        .Clr    (Clr),
        .sclr_i (state_q == S_LOAD),
        .inc_i  (state_q == S_SHIFT),
        .cnt_o  (Cnt),
        .term_o (last_shift)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (Start) state_d = S_LOAD;
            S_LOAD:  state_d = S_TEST;
            // An unknown Q0 falls through to the else arm and skips the add.
            S_TEST:  if (Q0) state_d = S_ADD; else state_d = S_SHIFT;
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: state_d = last_shift ? S_DONE : S_TEST;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are flops aligned with state_q.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= S_IDLE;
            ld_q    <= 1'b0;
            sh_q    <= 1'b0;
            add_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_q    <= (state_d == S_LOAD);
            sh_q    <= (state_d == S_SHIFT);
            add_q   <= (state_d == S_ADD);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign Ld   = ld_q;
    assign Sh   = sh_q;
    assign Add  = add_q;
    assign Busy = busy_q;
    assign Done = done_q;
    assign Di   = DI_RIGHT;

endmodule

`default_nettype wire

// File: tb/tb_shift_mult_ctrl.sv
// ============================================================================
// Module  : tb_shift_mult_ctrl
// Brief   : Self-checking bench: controller plus a behavioural shift-add
//           datapath, checked against product, latency and add-slot rules.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_mult_ctrl;
    import shift_mult_pkg::*;

    localparam int N = 8;
    localparam int W = $clog2(N + 1);

    logic         Clk = 1'b0;
    logic         Clr = 1'b1;
    logic         Start = 1'b0;
    logic         Q0;
    logic         Ld, Sh, Di, Add, Busy, Done;
    logic [W-1:0] Cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] tb_m = '0;
    logic [7:0] tb_b = '0;
    logic [8:0] acc_q = '0;
    logic [7:0] mq_q = '0;
    logic [7:0] mc_q = '0;

    shift_mult_ctrl #(.NSIZE(N), .CNTW(W)) dut (
        .Clk   (Clk),
        .Clr   (Clr),
        .Start (Start),
        .Q0    (Q0),
        .Ld    (Ld),
        .Sh    (Sh),
        .Di    (Di),
        .Add   (Add),
        .Busy  (Busy),
        .Done  (Done),
        .Cnt   (Cnt)
    );

    always #5 Clk = ~Clk;

    // Behavioural shift register and accumulator driven by the controller.
    assign Q0 = mq_q[0];
    always @(posedge Clk) begin
        if (Ld) begin
            acc_q <= '0;
            mq_q  <= tb_m;
            mc_q  <= tb_b;
        end else if (Add) begin
            acc_q <= acc_q + {1'b0, mc_q};
        end else if (Sh) begin
            {acc_q, mq_q} <= {acc_q, mq_q} >> 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is positioned just after the negedge of cycle 1 (LOAD).
    task automatic watch_op(input logic [7:0] m, input logic [7:0] b,
                            input bit repulse, input bit hold);
        int      k = 1;
        int      sh_seen = 0;
        int      add_mask = 0;
        bit      done_seen = 1'b0;
        while (k <= 100) begin
            check("busy", 32'(Busy), 32'd1);
            check("di", 32'(Di), 32'd0);
            check("excl", 32'((int'(Ld) + int'(Sh) + int'(Add)) <= 1), 32'd1);
            check("ld", 32'(Ld), 32'(k == 1));
            if (k >= 2) check("cnt", 32'(Cnt), 32'(sh_seen));
            if (Add) add_mask |= (1 << sh_seen);
            if (Sh) sh_seen++;
            if (Done) begin
                done_seen = 1'b1;
                break;
            end
            if (!hold) Start = repulse && (k == 5 || k == 12);
            @(negedge Clk);
            k++;
        end
        if (!hold) Start = 1'b0;
        check("done_seen", 32'(done_seen), 32'd1);
        check("latency", 32'(k), 32'(2 * N + $countones(m) + 2));
        check("shifts", 32'(sh_seen), 32'(N));
        check("add_slots", 32'(add_mask), 32'(m));
        check("cnt_done", 32'(Cnt), 32'(N));
        check("product", 32'({acc_q[7:0], mq_q}), 32'(m) * 32'(b));
    endtask

    task automatic run_op(input logic [7:0] m, input logic [7:0] b, input bit repulse);
        tb_m  = m;
        tb_b  = b;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        watch_op(m, b, repulse, 1'b0);
        @(negedge Clk);
        check("idle_busy", 32'(Busy), 32'd0);
        check("idle_done", 32'(Done), 32'd0);
        check("idle_cnt_hold", 32'(Cnt), 32'(N));
    endtask

    initial begin
        logic [7:0] m2;
        bit         found;

        repeat (2) @(negedge Clk);
        check("rst_ld", 32'(Ld), 32'd0);
        check("rst_sh", 32'(Sh), 32'd0);
        check("rst_add", 32'(Add), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_cnt", 32'(Cnt), 32'd0);
        Clr = 1'b0;
        @(negedge Clk);
        check("post_rst_busy", 32'(Busy), 32'd0);

        run_op(8'h00, 8'h5A, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0);
        run_op(8'h81, 8'($urandom), 1'b0);
        run_op(8'($urandom), 8'($urandom), 1'b1);

        // Start held high across two back-to-back operations.
        tb_m  = 8'h6B;
        tb_b  = 8'h3C;
        m2    = 8'($urandom);
        Start = 1'b1;
        @(negedge Clk);
        watch_op(8'h6B, 8'h3C, 1'b0, 1'b1);
        tb_m = m2;
        @(negedge Clk);
        check("hold_gap_busy", 32'(Busy), 32'd0);
        check("hold_gap_ld", 32'(Ld), 32'd0);
        @(negedge Clk);
        watch_op(m2, 8'h3C, 1'b0, 1'b1);
        Start = 1'b0;
        @(negedge Clk);
        check("hold_end_busy", 32'(Busy), 32'd0);

        // Asynchronous clear in the middle of a SHIFT cycle.
        tb_m  = 8'hA5;
        tb_b  = 8'h17;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Sh && Cnt == W'(3)) begin
                found = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        check("clr_reach_shift", 32'(found), 32'd1);
        #2 Clr = 1'b1;
        #1;
        check("clr_ld", 32'(Ld), 32'd0);
        check("clr_sh", 32'(Sh), 32'd0);
        check("clr_add", 32'(Add), 32'd0);
        check("clr_busy", 32'(Busy), 32'd0);
        check("clr_done", 32'(Done), 32'd0);
        check("clr_cnt", 32'(Cnt), 32'd0);
        check("clr_di", 32'(Di), 32'd0);
        repeat (2) @(negedge Clk);
        check("clr_hold_done", 32'(Done), 32'd0);
        Clr = 1'b0;
        @(negedge Clk);
        check("clr_rel_busy", 32'(Busy), 32'd0);
        check("clr_rel_done", 32'(Done), 32'd0);
        run_op(8'($urandom), 8'($urandom), 1'b0);

        for (int t = 0; t < 1000; t++) begin
            run_op(8'($urandom), 8'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
